adc_accum_bank: RTL and testbench
=================================

ADC_ACCUM_BANK -- requirements
Module: adc_accum_bank

Interface
REQ-001 Parameter NCH, default 16, number of ADC channels (1..32).
REQ-002 Parameter DATA_W, default 16, width of each ADC sample.
REQ-003 Parameter SUM_W, default 32, accumulator width (SUM_W >= DATA_W+1).
REQ-004 Parameter CNT_W, default 16, sample-count width.
REQ-005 Parameter SIGNED_MODE, default 0, 0 = unsigned samples/sums, 1 = two's-complement.
REQ-006 Port clk  input  1  single clock; all logic on rising edge.
REQ-007 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 Port sclr  input  1  synchronous clear of live accumulators, counts and overflow flags.
REQ-009 Port adcdata  input  NCH*DATA_W  packed samples, channel k at [k*DATA_W +: DATA_W].
REQ-010 Port adcready  input  NCH  per-channel sample-valid strobe, one sample per high cycle.
REQ-011 Port chan_en  input  NCH  per-channel accumulate enable; disabled channel ignores adcready.
REQ-012 Port snap  input  1  snapshot strobe: latch all channels and restart window.
REQ-013 Port result  output  NCH*(CNT_W+SUM_W)  latched results, channel k = {count, sum} at [k*(CNT_W+SUM_W) +: CNT_W+SUM_W].
REQ-014 Port ovf  output  NCH  latched per-channel overflow flags of last window.
REQ-015 Port snap_valid  output  1  one-cycle pulse when result/ovf updated.
REQ-016 Port busy  output  NCH  live indicator: channel has count != 0 in current window.

Function
REQ-017 Each channel SHALL hold a live sum (SUM_W), live count (CNT_W) and live sticky overflow bit.
REQ-018 On cycle with adcready[k]=1, chan_en[k]=1, no sclr/snap, live sum SHALL become sum + sample (sign-extended if SIGNED_MODE=1, zero-extended otherwise) and count SHALL increment, visible next cycle.
REQ-019 Sum SHALL saturate: unsigned at 2^SUM_W-1; signed at +2^(SUM_W-1)-1 / -2^(SUM_W-1); any saturation SHALL set live overflow bit.
REQ-020 Count SHALL saturate at 2^CNT_W-1 and set live overflow bit; sum continues accumulating.
REQ-021 On snap=1, result and ovf SHALL load each channel's live values including that cycle's sample if adcready[k]&chan_en[k], visible next cycle; snap_valid SHALL pulse high that next cycle only.
REQ-022 On snap=1, live sum, count and overflow SHALL clear the same edge; next window starts with zero.
REQ-023 Back-to-back snap cycles SHALL each produce a snap_valid pulse; second snapshot holds only samples of its own cycle.
REQ-024 sclr=1 SHALL clear live sum, count, overflow for all channels; the same-cycle sample SHALL be discarded; result/ovf SHALL be unaffected.
REQ-025 sclr and snap together: result SHALL latch live values excluding the same-cycle sample, snap_valid pulses, live state clears.
REQ-026 chan_en[k] deasserted mid-window SHALL freeze channel k live state; it still participates in snap/sclr.
REQ-027 busy[k] SHALL equal (live count[k] != 0), registered with live state.
REQ-028 Channels SHALL be fully independent; simultaneous adcready on all NCH channels SHALL be accepted in one cycle.
REQ-029 Latency adcready to live update 1 cycle; snap to result/snap_valid 1 cycle; no backpressure.

Reset
REQ-030 rst_n=0 SHALL immediately clear live sums, counts, overflow bits, result, ovf, busy and snap_valid to 0, independent of clk.
REQ-031 Reset asserted mid-window SHALL discard all accumulated data; first sample after rst_n deasserts SHALL be counted normally.

Verification
REQ-032 Defaults, channel 0 gets samples 100, 200, 300, then snap -> result ch0 = {count 3, sum 600}, snap_valid 1 cycle, live cleared.
REQ-033 SIGNED_MODE=1, SUM_W=18, DATA_W=16, ch3 fed 0x7FFF repeatedly -> sum saturates at 131071, ovf[3]=1 after snap; ovf[3]=0 after next clean window.
REQ-034 CNT_W=4, 20 samples of value 1 on ch1 then snap -> count 15, sum 20, ovf[1]=1.
REQ-035 Sample 50 on ch2 with snap same cycle -> result sum 50 count 1; with sclr+snap same cycle -> sample excluded; sclr alone leaves result unchanged.
REQ-036 chan_en[5]=0 with adcready[5] pulsing, all 16 channels otherwise active simultaneously -> ch5 result {0,0}, others correct.
REQ-037 rst_n pulsed low between clock edges mid-window -> all outputs 0 without clock edge; subsequent window counts from zero.

Source files
------------

// File: rtl/adc_accum_bank.sv
// Bank of independent per-channel ADC accumulators. Each channel keeps a live
// saturating sum, count and sticky overflow that a snapshot copies and restarts.
module adc_accum_bank #(
  parameter int NCH         = 16,
  parameter int DATA_W      = 16,
  parameter int SUM_W       = 32,
  parameter int CNT_W       = 16,
  parameter int SIGNED_MODE = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sclr,
  input  logic [NCH*DATA_W-1:0]          adcdata,
  input  logic [NCH-1:0]                 adcready,
  input  logic [NCH-1:0]                 chan_en,
  input  logic                           snap,
  output logic [NCH*(CNT_W+SUM_W)-1:0]   result,
  output logic [NCH-1:0]                 ovf,
  output logic                           snap_valid,
  output logic [NCH-1:0]                 busy
);

  localparam int RES_W = CNT_W + SUM_W;
  localparam logic [SUM_W-1:0] U_MAX   = {SUM_W{1'b1}};
  localparam logic [SUM_W-1:0] S_MAX   = {1'b0, {(SUM_W-1){1'b1}}};
  localparam logic [SUM_W-1:0] S_MIN   = {1'b1, {(SUM_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic snap_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_valid_q <= 1'b0;
    end else begin
      snap_valid_q <= snap;
    end
  end

  assign snap_valid = snap_valid_q;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [DATA_W-1:0] sample;
    logic [SUM_W:0]    sample_x;
    logic [SUM_W:0]    sum_x;
    logic [SUM_W:0]    add_x;
    logic [SUM_W-1:0]  sum_q, sum_d, sum_acc, win_sum;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_acc, win_cnt;
    logic              ovf_live_q, ovf_live_d, ovf_acc, win_ovf;
    logic              sat_sum, sat_cnt, take;
    logic [RES_W-1:0]  res_q;
    logic              ovf_res_q;

    assign sample = adcdata[k*DATA_W +: DATA_W];
    // sclr discards the same-cycle sample, even when snap is also high
    assign take   = adcready[k] & chan_en[k] & ~sclr;

    // One extra bit of headroom so overflow is visible in the top two bits
    always_comb begin
      if (SIGNED_MODE != 0) begin
        sample_x = {{(SUM_W+1-DATA_W){sample[DATA_W-1]}}, sample};
        sum_x    = {sum_q[SUM_W-1], sum_q};
      end else begin
        sample_x = {{(SUM_W+1-DATA_W){1'b0}}, sample};
        sum_x    = {1'b0, sum_q};
      end
      add_x = sum_x + sample_x;
    end

    always_comb begin
      sum_acc = add_x[SUM_W-1:0];
      sat_sum = 1'b0;
      if (SIGNED_MODE != 0) begin
        if (add_x[SUM_W] != add_x[SUM_W-1]) begin
          sat_sum = 1'b1;
          sum_acc = add_x[SUM_W] ? S_MIN : S_MAX;
        end
      end else if (add_x[SUM_W]) begin
        sat_sum = 1'b1;
        sum_acc = U_MAX;
      end

      cnt_acc = cnt_q + 1'b1;
      sat_cnt = 1'b0;
      if (cnt_q == CNT_MAX) begin
        cnt_acc = cnt_q;
        sat_cnt = 1'b1;
      end
      ovf_acc = ovf_live_q | sat_sum | sat_cnt;
    end

    // Window totals including this cycle's accepted sample; feed both paths
    always_comb begin
      win_sum = sum_q;
      win_cnt = cnt_q;
      win_ovf = ovf_live_q;
      if (take) begin
        win_sum = sum_acc;
        win_cnt = cnt_acc;
        win_ovf = ovf_acc;
      end
      sum_d      = win_sum;
      cnt_d      = win_cnt;
      ovf_live_d = win_ovf;
      if (sclr || snap) begin
        sum_d      = '0;
        cnt_d      = '0;
        ovf_live_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q      <= '0;
        cnt_q      <= '0;
        ovf_live_q <= 1'b0;
        res_q      <= '0;
        ovf_res_q  <= 1'b0;
      end else begin
        sum_q      <= sum_d;
        cnt_q      <= cnt_d;
        ovf_live_q <= ovf_live_d;
        if (snap) begin
          res_q     <= {win_cnt, win_sum};
          ovf_res_q <= win_ovf;
        end
      end
    end

    assign result[k*RES_W +: RES_W] = res_q;
    assign ovf[k]                   = ovf_res_q;
    assign busy[k]                  = (cnt_q != '0);
  end

endmodule

// File: tb/tb_adc_accum_bank.sv
// Directed bench for adc_accum_bank: default, signed (SUM_W=18) and
// narrow-count (CNT_W=4, SUM_W=17) instances share one clock and reset.
module tb_adc_accum_bank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default instance: NCH 16, DATA 16, SUM 32, CNT 16 -> 48 bits per channel
  logic         a_sclr, a_snap, a_snap_valid;
  logic [255:0] a_data;
  logic [15:0]  a_ready, a_en, a_ovf, a_busy;
  logic [767:0] a_result;

  // signed instance: SUM 18, CNT 16 -> 34 bits per channel
  logic         s_sclr, s_snap, s_snap_valid;
  logic [255:0] s_data;
  logic [15:0]  s_ready, s_en, s_ovf, s_busy;
  logic [543:0] s_result;

  // narrow count instance: NCH 4, SUM 17, CNT 4 -> 21 bits per channel
  logic         c_sclr, c_snap, c_snap_valid;
  logic [63:0]  c_data;
  logic [3:0]   c_ready, c_en, c_ovf, c_busy;
  logic [83:0]  c_result;

  int n_tests = 0;
  int n_fail  = 0;

  adc_accum_bank dut_a (
    .clk(clk), .rst_n(rst_n), .sclr(a_sclr), .adcdata(a_data), .adcready(a_ready),
    .chan_en(a_en), .snap(a_snap), .result(a_result), .ovf(a_ovf),
    .snap_valid(a_snap_valid), .busy(a_busy)
  );

  adc_accum_bank #(.NCH(16), .DATA_W(16), .SUM_W(18), .CNT_W(16), .SIGNED_MODE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .sclr(s_sclr), .adcdata(s_data), .adcready(s_ready),
    .chan_en(s_en), .snap(s_snap), .result(s_result), .ovf(s_ovf),
    .snap_valid(s_snap_valid), .busy(s_busy)
  );

  adc_accum_bank #(.NCH(4), .DATA_W(16), .SUM_W(17), .CNT_W(4), .SIGNED_MODE(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .sclr(c_sclr), .adcdata(c_data), .adcready(c_ready),
    .chan_en(c_en), .snap(c_snap), .result(c_result), .ovf(c_ovf),
    .snap_valid(c_snap_valid), .busy(c_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_ready = '0; a_snap = 1'b0; a_sclr = 1'b0;
    s_ready = '0; s_snap = 1'b0; s_sclr = 1'b0;
    c_ready = '0; c_snap = 1'b0; c_sclr = 1'b0;
  endtask

  task automatic a_put(input int k, input logic [15:0] v);
    a_data[k*16 +: 16] = v;
    a_ready[k] = 1'b1;
  endtask

  task automatic s_put(input int k, input logic [15:0] v);
    s_data[k*16 +: 16] = v;
    s_ready[k] = 1'b1;
  endtask

  task automatic c_put(input int k, input logic [15:0] v);
    c_data[k*16 +: 16] = v;
    c_ready[k] = 1'b1;
  endtask

  initial begin
    a_data = '0; s_data = '0; c_data = '0;
    a_en = '1; s_en = '1; c_en = '1;
    idle_all();
    a_put(0, 16'd77);

    // reset holds everything at zero even with a sample present
    tick();
    chk("rst_result", {63'd0, a_result != '0}, 64'd0);
    chk("rst_busy", a_busy, 64'd0);
    chk("rst_snap_valid", a_snap_valid, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_all();

    // three samples then snap
    a_put(0, 16'd100); tick();
    chk("busy_after_first", a_busy[0], 64'd1);
    idle_all(); a_put(0, 16'd200); tick();
    idle_all(); a_put(0, 16'd300); tick();
    chk("snap_valid_idle", a_snap_valid, 64'd0);
    idle_all(); a_snap = 1'b1; tick();
    chk("ch0_count", a_result[0*48+32 +: 16], 64'd3);
    chk("ch0_sum", a_result[0*48 +: 32], 64'd600);
    chk("snap_valid_pulse", a_snap_valid, 64'd1);
    chk("ch0_live_cleared", a_busy[0], 64'd0);
    idle_all(); tick();
    chk("snap_valid_drop", a_snap_valid, 64'd0);
    chk("ch0_result_hold", a_result[0*48 +: 48], {16'd0, 16'd3, 32'd600});

    // sample on the snap cycle is included
    idle_all(); a_put(2, 16'd50); a_snap = 1'b1; tick();
    chk("ch2_snap_same_cnt", a_result[2*48+32 +: 16], 64'd1);
    chk("ch2_snap_same_sum", a_result[2*48 +: 32], 64'd50);
    chk("ch0_new_window", a_result[0*48 +: 48], 64'd0);
    chk("ch2_live_after_snap", a_busy[2], 64'd0);

    // sclr+snap: live value latched, same-cycle sample excluded
    idle_all(); a_put(2, 16'd50); tick();
    idle_all(); a_put(2, 16'd60); a_sclr = 1'b1; a_snap = 1'b1; tick();
    chk("sclr_snap_cnt", a_result[2*48+32 +: 16], 64'd1);
    chk("sclr_snap_sum", a_result[2*48 +: 32], 64'd50);
    chk("sclr_snap_valid", a_snap_valid, 64'd1);
    chk("sclr_snap_busy", a_busy[2], 64'd0);

    // sclr alone: result untouched, live and same-cycle sample discarded
    idle_all(); a_put(2, 16'd70); tick();
    idle_all(); a_put(2, 16'd80); a_sclr = 1'b1; tick();
    chk("sclr_result_kept", a_result[2*48 +: 48], {16'd0, 16'd1, 32'd50});
    chk("sclr_busy", a_busy[2], 64'd0);
    chk("sclr_no_valid", a_snap_valid, 64'd0);
    idle_all(); a_snap = 1'b1; tick();
    chk("sclr_then_snap", a_result[2*48 +: 48], 64'd0);

    // back-to-back snaps
    idle_all(); a_put(4, 16'd10); tick();
    idle_all(); a_put(4, 16'd5); a_snap = 1'b1; tick();
    chk("b2b_first", a_result[4*48 +: 48], {16'd0, 16'd2, 32'd15});
    idle_all(); a_put(4, 16'd7); a_snap = 1'b1; tick();
    chk("b2b_second", a_result[4*48 +: 48], {16'd0, 16'd1, 32'd7});
    chk("b2b_valid", a_snap_valid, 64'd1);

    // all channels at once, ch5 disabled
    idle_all(); a_en = 16'hFFDF;
    for (int k = 0; k < 16; k++) a_put(k, 16'(k + 1));
    tick();
    idle_all();
    for (int k = 0; k < 16; k++) a_put(k, 16'(2 * (k + 1)));
    tick();
    chk("ch5_not_busy", a_busy[5], 64'd0);
    idle_all(); a_snap = 1'b1; tick();
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("all_ch%0d_cnt", k), a_result[k*48+32 +: 16], (k == 5) ? 64'd0 : 64'd2);
      chk($sformatf("all_ch%0d_sum", k), a_result[k*48 +: 32], (k == 5) ? 64'd0 : 64'(3 * (k + 1)));
    end
    chk("all_ovf", a_ovf, 64'd0);
    a_en = '1;

    // disable mid-window freezes live state
    idle_all(); a_put(6, 16'd4); tick();
    idle_all(); a_en[6] = 1'b0; a_put(6, 16'd9); tick();
    chk("freeze_busy", a_busy[6], 64'd1);
    idle_all(); a_en[6] = 1'b1; a_snap = 1'b1; tick();
    chk("freeze_result", a_result[6*48 +: 48], {16'd0, 16'd1, 32'd4});

    // signed: positive saturation, negative saturation, small negative sum
    for (int i = 0; i < 6; i++) begin
      idle_all();
      s_put(3, 16'h7FFF);
      if (i < 2) s_put(0, 16'hFFFF);
      if (i < 5) s_put(1, 16'h8000);
      tick();
    end
    idle_all(); s_snap = 1'b1; tick();
    chk("s_ch3_sum_sat", s_result[3*34 +: 18], 64'd131071);
    chk("s_ch3_cnt", s_result[3*34+18 +: 16], 64'd6);
    chk("s_ch3_ovf", s_ovf[3], 64'd1);
    chk("s_ch1_sum_min", s_result[1*34 +: 18], 64'h20000);
    chk("s_ch1_ovf", s_ovf[1], 64'd1);
    chk("s_ch0_sum_neg", s_result[0*34 +: 18], 64'h3FFFE);
    chk("s_ch0_ovf", s_ovf[0], 64'd0);
    idle_all(); s_put(3, 16'h7FFF); s_snap = 1'b1; tick();
    chk("s_ch3_clean_sum", s_result[3*34 +: 18], 64'd32767);
    chk("s_ch3_clean_ovf", s_ovf[3], 64'd0);

    // narrow count saturation and unsigned sum saturation
    for (int i = 0; i < 20; i++) begin
      idle_all();
      c_put(1, 16'd1);
      if (i < 3) c_put(2, 16'hFFFF);
      tick();
    end
    idle_all(); c_snap = 1'b1; tick();
    chk("c_ch1_cnt_sat", c_result[1*21+17 +: 4], 64'd15);
    chk("c_ch1_sum", c_result[1*21 +: 17], 64'd20);
    chk("c_ch2_sum_sat", c_result[2*21 +: 17], 64'h1FFFF);
    chk("c_ovf", c_ovf, 64'b0110);

    // asynchronous reset between edges
    idle_all(); a_put(0, 16'd9); tick();
    idle_all(); a_snap = 1'b1; s_put(0, 16'd3); tick();
    chk("pre_rst_valid", a_snap_valid, 64'd1);
    chk("pre_rst_s_busy", s_busy[0], 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_a_result", {63'd0, a_result != '0}, 64'd0);
    chk("arst_s_result", {63'd0, s_result != '0}, 64'd0);
    chk("arst_snap_valid", a_snap_valid, 64'd0);
    chk("arst_busy", {s_busy, a_busy}, 64'd0);
    chk("arst_ovf", {c_ovf, s_ovf, a_ovf}, 64'd0);
    #1 rst_n = 1'b1;
    idle_all(); a_put(0, 16'd11); a_snap = 1'b1; s_snap = 1'b1; tick();
    chk("post_rst_a", a_result[0*48 +: 48], {16'd0, 16'd1, 32'd11});
    chk("post_rst_s", s_result[0*34 +: 34], 64'd0);

    idle_all(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
